// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: loader bank states, bit reversal
// and the unity twiddle constant.
package fft_pkg;

    localparam int unsigned DEF_N    = 16;
    localparam int unsigned DEF_Q    = 8;
    localparam int unsigned DEF_NPTS = 8;

    localparam logic [31:0] TW_ONE = 32'd1 << DEF_Q;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_FULL,
        ST_DRAIN
    } ldr_state_e;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) begin
                r[5'(i)] = v[5'(w - 1 - i)];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] tw_one(input int unsigned q);
        return 32'd1 << q;
    endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// One frame of complex samples: a DEPTH x W register array with a single
// write port and two asynchronous read ports.
module fft_sample_bank #(
    parameter  int unsigned W     = 32,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr0_i,
    input  logic [AW-1:0] raddr1_i,
    output logic [W-1:0]  rdata0_o,
    output logic [W-1:0]  rdata1_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fft_bitrev_loader.sv
// Natural-order sample loader feeding stage-1 butterfly pairs in bit-reversed order.
// Define FFT_BITREV_PINGPONG_EN for two banks (fill one while the other drains).
module fft_bitrev_loader
    import fft_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned Q    = DEF_Q,
    parameter int unsigned NPTS = DEF_NPTS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_r,
    input  logic [N-1:0] in_i,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] x0_r,
    output logic [N-1:0] x0_i,
    output logic [N-1:0] x1_r,
    output logic [N-1:0] x1_i,
    output logic [N-1:0] tw_r,
    output logic [N-1:0] tw_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_first,
    output logic         out_last
);

    localparam int unsigned      LOG2N   = $clog2(NPTS);
    localparam int unsigned      PW      = LOG2N - 1;
    localparam logic [LOG2N-1:0] WP_LAST = LOG2N'(NPTS - 1);
    localparam logic [PW-1:0]    P_LAST  = PW'(NPTS / 2 - 1);
    localparam logic [N-1:0]     TW_VAL  = N'(tw_one(Q));

    ldr_state_e       st_q [2];
    ldr_state_e       st_d [2];
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;

    logic [LOG2N-1:0] wp_q, wp_d;
    logic [PW-1:0]    p_q, p_d;
    logic             in_ready_q, in_ready_d;
    logic             load;

    logic [N-1:0]     x0_r_q, x0_r_d, x0_i_q, x0_i_d;
    logic [N-1:0]     x1_r_q, x1_r_d, x1_i_q, x1_i_d;
    logic             out_valid_q, out_valid_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;

    logic             accept, last_in, last_hs;
    logic [LOG2N-1:0] raddr0, raddr1;
    logic [2*N-1:0]   bank_rd0 [2];
    logic [2*N-1:0]   bank_rd1 [2];
    logic [2*N-1:0]   rd0_sel, rd1_sel;

    assign accept  = in_valid && in_ready_q;
    assign last_in = accept && (wp_q == WP_LAST);
    assign last_hs = out_valid_q && out_ready && out_last_q;

    assign raddr0  = LOG2N'(bitrev(32'({p_q, 1'b0}), LOG2N));
    assign raddr1  = LOG2N'(bitrev(32'({p_q, 1'b1}), LOG2N));
    assign rd0_sel = bank_rd0[rd_q];
    assign rd1_sel = bank_rd1[rd_q];

`ifdef FFT_BITREV_PINGPONG_EN
    fft_sample_bank #(.W(2 * N), .DEPTH(NPTS)) u_bank0 (
        .clk      (clk),
        .we_i     (accept && !wr_q),
        .waddr_i  (wp_q),
        .wdata_i  ({in_r, in_i}),
        .raddr0_i (raddr0),
        .raddr1_i (raddr1),
        .rdata0_o (bank_rd0[0]),
        .rdata1_o (bank_rd1[0])
    );

    fft_sample_bank #(.W(2 * N), .DEPTH(NPTS)) u_bank1 (
        .clk      (clk),
        .we_i     (accept && wr_q),
        .waddr_i  (wp_q),
        .wdata_i  ({in_r, in_i}),
        .raddr0_i (raddr0),
        .raddr1_i (raddr1),
        .rdata0_o (bank_rd0[1]),
        .rdata1_o (bank_rd1[1])
    );
`else
    fft_sample_bank #(.W(2 * N), .DEPTH(NPTS)) u_bank0 (
        .clk      (clk),
        .we_i     (accept),
        .waddr_i  (wp_q),
        .wdata_i  ({in_r, in_i}),
        .raddr0_i (raddr0),
        .raddr1_i (raddr1),
        .rdata0_o (bank_rd0[0]),
        .rdata1_o (bank_rd1[0])
    );

    assign bank_rd0[1] = '0;
    assign bank_rd1[1] = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= '{ST_FILL, ST_FILL};
            wr_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            st_q <= st_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // The drain side owns bank rd_q, the fill side bank wr_q; with one bank both stay 0.
    always_comb begin
        st_d = st_q;
        wr_d = wr_q;
        rd_d = rd_q;
        if (st_q[rd_q] == ST_FULL) begin
            st_d[rd_q] = ST_DRAIN;
        end else if (st_q[rd_q] == ST_DRAIN && last_hs) begin
            st_d[rd_q] = ST_FILL;
`ifdef FFT_BITREV_PINGPONG_EN
            rd_d = ~rd_q;
            // A waiting full bank starts draining immediately to keep the inter-frame gap short.
            if (st_q[~rd_q] == ST_FULL) begin
                st_d[~rd_q] = ST_DRAIN;
            end
`endif
        end
        if (last_in) begin
            st_d[wr_q] = ST_FULL;
`ifdef FFT_BITREV_PINGPONG_EN
            wr_d = ~wr_q;
`endif
        end
    end

    always_comb begin
        in_ready_d  = (st_d[wr_d] == ST_FILL);
        wp_d        = accept ? wp_q + 1'b1 : wp_q;
        load        = (st_q[rd_q] == ST_DRAIN) && !(out_valid_q && out_last_q)
                      && (!out_valid_q || out_ready);
        p_d         = load ? p_q + 1'b1 : p_q;

        x0_r_d      = x0_r_q;
        x0_i_d      = x0_i_q;
        x1_r_d      = x1_r_q;
        x1_i_d      = x1_i_q;
        out_valid_d = out_valid_q && !out_ready;
        out_first_d = out_first_q && !out_ready;
        out_last_d  = out_last_q && !out_ready;

        if (load) begin
            x0_r_d      = rd0_sel[2*N-1:N];
            x0_i_d      = rd0_sel[N-1:0];
            x1_r_d      = rd1_sel[2*N-1:N];
            x1_i_d      = rd1_sel[N-1:0];
            out_valid_d = 1'b1;
            out_first_d = (p_q == '0);
            out_last_d  = (p_q == P_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b0;
            wp_q        <= '0;
            p_q         <= '0;
            x0_r_q      <= '0;
            x0_i_q      <= '0;
            x1_r_q      <= '0;
            x1_i_q      <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            wp_q        <= wp_d;
            p_q         <= p_d;
            x0_r_q      <= x0_r_d;
            x0_i_q      <= x0_i_d;
            x1_r_q      <= x1_r_d;
            x1_i_q      <= x1_i_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign x0_r      = x0_r_q;
    assign x0_i      = x0_i_q;
    assign x1_r      = x1_r_q;
    assign x1_i      = x1_i_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign tw_r      = out_valid_q ? TW_VAL : '0;
    assign tw_i      = '0;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed, table-driven bench for fft_bitrev_loader (NPTS=8, Q=8, N=16).
module tb_fft_bitrev_loader;

    logic        clk;
    logic        rst;
    logic [15:0] in_r, in_i;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x0_r, x0_i, x1_r, x1_i, tw_r, tw_i;
    logic        out_valid, out_ready, out_first, out_last;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

`ifdef FFT_BITREV_PINGPONG_EN
    localparam logic RDY_DRAIN = 1'b1;
`else
    localparam logic RDY_DRAIN = 1'b0;
`endif

    typedef struct {
        logic [7:0][15:0] re;
        logic [7:0][15:0] im;
        int unsigned      stall_pair;
        int unsigned      stall_len;
        logic [3:0][15:0] x0r;
        logic [3:0][15:0] x0i;
        logic [3:0][15:0] x1r;
        logic [3:0][15:0] x1i;
    } frame_t;

    frame_t frames [3];

    fft_bitrev_loader #(.N(16), .Q(8), .NPTS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0_r      (x0_r),
        .x0_i      (x0_i),
        .x1_r      (x1_r),
        .x1_i      (x1_i),
        .tw_r      (tw_r),
        .tw_i      (tw_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, actual timeout, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_first"}, 32'(out_first), 0);
        chk({tag, "_out_last"}, 32'(out_last), 0);
        chk({tag, "_x0_r"}, 32'(x0_r), 0);
        chk({tag, "_x0_i"}, 32'(x0_i), 0);
        chk({tag, "_x1_r"}, 32'(x1_r), 0);
        chk({tag, "_x1_i"}, 32'(x1_i), 0);
        chk({tag, "_tw_r"}, 32'(tw_r), 0);
        chk({tag, "_tw_i"}, 32'(tw_i), 0);
    endtask

    task automatic feed(input int fi, input int unsigned nsamp, output int unsigned lowcnt);
        int unsigned k;
        int unsigned cyc;
        logic        rdy;
        logic [2:0]  ki;
        k      = 0;
        cyc    = 0;
        lowcnt = 0;
        while (k < nsamp && cyc < 100) begin
            ki       = 3'(k);
            in_r     = frames[fi].re[ki];
            in_i     = frames[fi].im[ki];
            in_valid = 1'b1;
            rdy      = in_ready;
            if (!rdy) lowcnt++;
            step();
            cyc++;
            if (rdy) k++;
        end
        in_valid = 1'b0;
        chk("feed_done", k, nsamp);
    endtask

    task automatic collect(input int fi, input bit chk_lat);
        int unsigned wcnt;
        int unsigned cyc;
        int unsigned pi;
        int unsigned stalled;
        logic [1:0]  pidx;
        out_ready = 1'b1;
        wcnt = 0;
        while (!out_valid && wcnt < 40) begin
            step();
            wcnt++;
        end
        chk("first_valid_seen", 32'(out_valid), 1);
        if (chk_lat) chk("latency", wcnt, 2);
        pi      = 0;
        cyc     = 0;
        stalled = 0;
        while (pi < 4 && cyc < 40) begin
            if (out_valid) begin
                pidx = 2'(pi);
                chk("x0_r", 32'(x0_r), 32'(frames[fi].x0r[pidx]));
                chk("x0_i", 32'(x0_i), 32'(frames[fi].x0i[pidx]));
                chk("x1_r", 32'(x1_r), 32'(frames[fi].x1r[pidx]));
                chk("x1_i", 32'(x1_i), 32'(frames[fi].x1i[pidx]));
                chk("out_first", 32'(out_first), 32'(pi == 0));
                chk("out_last", 32'(out_last), 32'(pi == 3));
                chk("tw_r", 32'(tw_r), 32'h100);
                chk("tw_i", 32'(tw_i), 0);
                chk("in_ready_drain", 32'(in_ready), 32'(RDY_DRAIN));
                if (pi == frames[fi].stall_pair && stalled < frames[fi].stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    pi++;
                end
            end else begin
                out_ready = 1'b1;
            end
            step();
            cyc++;
        end
        out_ready = 1'b1;
        chk("pairs_done", pi, 4);
        chk("drain_cycles", cyc, 4 + frames[fi].stall_len);
        chk("valid_after", 32'(out_valid), 0);
        chk("tw_r_idle", 32'(tw_r), 0);
        chk("in_ready_after", 32'(in_ready), 1);
    endtask

    initial begin
        int unsigned lowd, low1, low2, wcnt;

        // Table entries list index 7 (or pair 3) first.
        frames[0].re  = {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
        frames[0].im  = {16'd70, 16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10, 16'd0};
        frames[0].stall_pair = 4;
        frames[0].stall_len  = 0;
        frames[0].x0r = {16'd3, 16'd1, 16'd2, 16'd0};
        frames[0].x1r = {16'd7, 16'd5, 16'd6, 16'd4};
        frames[0].x0i = {16'd30, 16'd10, 16'd20, 16'd0};
        frames[0].x1i = {16'd70, 16'd50, 16'd60, 16'd40};

        frames[1] = frames[0];
        frames[1].stall_pair = 1;
        frames[1].stall_len  = 3;

        frames[2].re  = {16'h0000, 16'h7FFE, 16'hFFFE, 16'h8001,
                         16'h0001, 16'h7FFF, 16'hFFFF, 16'h8000};
        frames[2].im  = {16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE,
                         16'hFFFE, 16'h8000, 16'h0000, 16'h7FFF};
        frames[2].stall_pair = 4;
        frames[2].stall_len  = 0;
        frames[2].x0r = {16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
        frames[2].x1r = {16'h0000, 16'hFFFE, 16'h7FFE, 16'h8001};
        frames[2].x0i = {16'hFFFE, 16'h0000, 16'h8000, 16'h7FFF};
        frames[2].x1i = {16'hFFFF, 16'h0001, 16'h8001, 16'h7FFE};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_r      = '0;
        in_i      = '0;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk_outputs_zero("reset");
        rst = 1'b0;
        step();
        chk("in_ready_post_reset", 32'(in_ready), 1);

        for (int fi = 0; fi < 3; fi++) begin
            feed(fi, 8, lowd);
            collect(fi, 1'b1);
        end

        // Two frames offered back to back.
        fork
            begin
                feed(0, 8, low1);
                feed(2, 8, low2);
            end
            begin
                collect(0, 1'b0);
                collect(2, 1'b0);
            end
        join
`ifdef FFT_BITREV_PINGPONG_EN
        chk("b2b_in_ready_low_cycles", low2, 0);
`else
        chk("b2b_in_ready_low_cycles", low2, 6);
`endif

        // Reset after 5 samples of a frame.
        feed(2, 5, lowd);
        rst = 1'b1;
        step();
        chk_outputs_zero("midframe_rst");
        rst = 1'b0;
        step();
        chk("in_ready_after_midframe_rst", 32'(in_ready), 1);
        feed(0, 8, lowd);
        collect(0, 1'b1);

        // Reset while a frame is draining.
        feed(0, 8, lowd);
        out_ready = 1'b1;
        wcnt = 0;
        while (!out_valid && wcnt < 40) begin
            step();
            wcnt++;
        end
        chk("drain_started", 32'(out_valid), 1);
        step();
        chk("second_pair_valid", 32'(out_valid), 1);
        rst = 1'b1;
        step();
        chk("middrain_out_valid", 32'(out_valid), 0);
        chk("middrain_in_ready", 32'(in_ready), 0);
        chk("middrain_x0_r", 32'(x0_r), 0);
        chk("middrain_tw_r", 32'(tw_r), 0);
        rst = 1'b0;
        step();
        chk("middrain_in_ready_back", 32'(in_ready), 1);
        chk("middrain_out_valid_idle", 32'(out_valid), 0);
        feed(1, 8, lowd);
        collect(1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
